fetch_stage: RTL

- Instruction-fetch stage and IF/ID pipeline register of the 5-stage RISC-V core.
- Holds the PC and issues one instruction-memory request at a time over a valid/ready request channel, with a valid-only response.
- Presents {pc, instr, valid} to decode through the IF/ID register.
- Consumes PCWrite/IF_ID_Write (load-use stall) from the hazard detection unit and branch_taken/branch_target (flush) from EX.

---
 rtl/fetch_stage.sv | 115 +++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, single-outstanding imem request channel,
// one-entry skid buffer for stalled responses, and the IF/ID register.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        PCWrite,
    input  logic        IF_ID_Write,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [31:0] IF_ID_pc,
    output logic [31:0] IF_ID_instr,
    output logic        IF_ID_valid
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD,
        DISCARD
    } state_t;

    state_t      state, state_nx;
    logic [31:0] pc;
    logic [31:0] skid;
    logic [31:0] instr;
    logic        rsp_ok;
    logic        have;
    logic        deliver;
    logic        fire;
    logic        capture;

    assign imem_req_valid = (state == REQ);
    assign imem_addr      = pc;
    assign fire           = imem_req_valid && imem_req_ready;

    // Responses outside WAIT are either stale (DISCARD) or protocol errors.
    assign rsp_ok  = imem_rsp_valid && (state == WAIT);
    assign have    = rsp_ok || (state == HOLD);
    assign instr   = (state == HOLD) ? skid : imem_rsp_data;
    assign deliver = PCWrite && IF_ID_Write && !branch_taken && have;

    always_comb begin
        state_nx = state;
        capture  = 1'b0;
        unique case (state)
            IDLE: state_nx = REQ;
            REQ: begin
                if (fire)
                    state_nx = branch_taken ? DISCARD : WAIT;
            end
            WAIT: begin
                if (branch_taken)
                    state_nx = imem_rsp_valid ? REQ : DISCARD;
                else if (imem_rsp_valid) begin
                    state_nx = deliver ? REQ : HOLD;
                    capture  = !deliver;
                end
            end
            HOLD: begin
                if (branch_taken || deliver)
                    state_nx = REQ;
            end
            DISCARD: begin
                // The in-flight response is consumed even if a new flush lands.
                if (imem_rsp_valid)
                    state_nx = REQ;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            pc    <= RESET_PC;
            skid  <= '0;
        end else begin
            state <= state_nx;
            if (capture)
                skid <= imem_rsp_data;
            if (branch_taken)
                pc <= {branch_target[31:2], 2'b00};
            else if (deliver)
                pc <= pc + 32'd4;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            IF_ID_pc    <= '0;
            IF_ID_instr <= NOP_INSTR;
            IF_ID_valid <= 1'b0;
        end else if (branch_taken) begin
            IF_ID_instr <= NOP_INSTR;
            IF_ID_valid <= 1'b0;
        end else if (deliver) begin
            IF_ID_pc    <= pc;
            IF_ID_instr <= instr;
            IF_ID_valid <= 1'b1;
        end else if (IF_ID_Write) begin
            IF_ID_instr <= NOP_INSTR;
            IF_ID_valid <= 1'b0;
        end
    end

endmodule
